// File: rtl/riscv_test_monitor_if.sv
// Decode-stage observation bundle: the instruction stream plus the core's gp (x3) value.
interface riscv_test_monitor_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] gp_value;

  modport master (output inst_valid, inst, gp_value);
  modport slave  (input  inst_valid, inst, gp_value);
endinterface

// File: rtl/riscv_test_monitor.sv
// riscv-tests end-of-test monitor: watches for the ECALL/EBREAK trap, samples gp and
// reports PASS/FAIL/TIMEOUT with cycle and retired-instruction counts.
//
// state | meaning
// IDLE  | core held in reset, counters cleared
// RUN   | test executing, counting cycles and retired instructions
// PASS  | trap seen with gp == PASS_VALUE (sticky)
// FAIL  | trap seen with any other gp, fail_test = gp >> 1 (sticky)
// TOUT  | no trap within TIMEOUT_CYCLES run cycles (sticky)
module riscv_test_monitor #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
  parameter int RET_W          = 32,
  parameter int TRIG_EBREAK    = 0,
  parameter int PASS_VALUE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     clear,
  riscv_test_monitor_if.slave      core,
  output logic [2:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [XLEN-1:0]          fail_test,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [RET_W-1:0]         retired_count,
  output logic                     halt_req,
  output logic [7:0]               led
);

  localparam logic [31:0]      INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0]      INST_EBREAK = 32'h0010_0073;
  localparam logic [CNT_W-1:0] TMR_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [XLEN-1:0]  GP_PASS     = XLEN'(PASS_VALUE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cyc_q, cyc_nxt;
  logic [CNT_W-1:0] tmr_q, tmr_nxt;
  logic [RET_W-1:0] ret_q, ret_nxt;
  logic [XLEN-1:0]  ft_q, ft_nxt;
  logic [7:0]       led_nxt;
  logic             trigger;

  assign trigger = core.inst_valid &&
                   ((core.inst == INST_ECALL) ||
                    ((TRIG_EBREAK != 0) && (core.inst == INST_EBREAK)));

  always_comb begin
    state_nxt = state_q;
    cyc_nxt   = cyc_q;
    tmr_nxt   = tmr_q;
    ret_nxt   = ret_q;
    ft_nxt    = ft_q;
    if (clear) begin
      state_nxt = S_IDLE;
      cyc_nxt   = '0;
      tmr_nxt   = TMR_LOAD;
      ret_nxt   = '0;
      ft_nxt    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cyc_nxt = '0;
          tmr_nxt = TMR_LOAD;
          ret_nxt = '0;
          ft_nxt  = '0;
          if (run) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!run) begin
            state_nxt = S_IDLE;
            cyc_nxt   = '0;
            tmr_nxt   = TMR_LOAD;
            ret_nxt   = '0;
            ft_nxt    = '0;
          end else begin
            if (core.inst_valid && (ret_q != {RET_W{1'b1}})) ret_nxt = ret_q + 1'b1;
            // cycle_count freezes on the exit cycle so it reports the last RUN cycle index
            if (trigger) begin
              if (core.gp_value == GP_PASS) begin
                state_nxt = S_PASS;
              end else begin
                state_nxt = S_FAIL;
                ft_nxt    = core.gp_value >> 1;
              end
            end else if (tmr_q == '0) begin
              state_nxt = S_TOUT;
            end else begin
              cyc_nxt = cyc_q + 1'b1;
              tmr_nxt = tmr_q - 1'b1;
            end
          end
        end
        S_PASS, S_FAIL, S_TOUT: state_nxt = state_q;
        default: begin
          state_nxt = S_IDLE;
          cyc_nxt   = '0;
          tmr_nxt   = TMR_LOAD;
          ret_nxt   = '0;
          ft_nxt    = '0;
        end
      endcase
    end
  end

  always_comb begin
    led_nxt = 8'h00;
    case (state_nxt)
      S_PASS:  led_nxt = 8'h01;
      S_FAIL:  led_nxt = {1'b1, ft_nxt[6:0]};
      S_TOUT:  led_nxt = 8'hFF;
      default: led_nxt = 8'h00;
    endcase
  end

  // Flags are registered from the next state so they line up with state every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      tmr_q    <= TMR_LOAD;
      ret_q    <= '0;
      ft_q     <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      halt_req <= 1'b0;
      led      <= 8'h00;
    end else begin
      state_q  <= state_nxt;
      cyc_q    <= cyc_nxt;
      tmr_q    <= tmr_nxt;
      ret_q    <= ret_nxt;
      ft_q     <= ft_nxt;
      done     <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TOUT);
      pass     <= (state_nxt == S_PASS);
      fail     <= (state_nxt == S_FAIL);
      timeout  <= (state_nxt == S_TOUT);
      halt_req <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TOUT);
      led      <= led_nxt;
    end
  end

  assign state         = state_q;
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;
  assign fail_test     = ft_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench: two monitor instances (ECALL-only / RET_W=32 and ECALL+EBREAK / RET_W=4)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_riscv_test_monitor;

  localparam int          TOUT   = 100;
  localparam int          CW     = $clog2(TOUT + 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst, run, clear;
  always #5 clk = ~clk;

  riscv_test_monitor_if #(.XLEN(32)) bus ();

  logic [2:0]  a_state, b_state;
  logic        a_done, a_pass, a_fail, a_tout, a_halt;
  logic        b_done, b_pass, b_fail, b_tout, b_halt;
  logic [31:0] a_ft, b_ft;
  logic [CW-1:0] a_cyc, b_cyc;
  logic [31:0] a_ret;
  logic [3:0]  b_ret;
  logic [7:0]  a_led, b_led;

  riscv_test_monitor #(.XLEN(32), .TIMEOUT_CYCLES(TOUT), .RET_W(32), .TRIG_EBREAK(0), .PASS_VALUE(1)) dut_a (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .core(bus.slave),
    .state(a_state), .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tout),
    .fail_test(a_ft), .cycle_count(a_cyc), .retired_count(a_ret), .halt_req(a_halt), .led(a_led));

  riscv_test_monitor #(.XLEN(32), .TIMEOUT_CYCLES(TOUT), .RET_W(4), .TRIG_EBREAK(1), .PASS_VALUE(1)) dut_b (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .core(bus.slave),
    .state(b_state), .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tout),
    .fail_test(b_ft), .cycle_count(b_cyc), .retired_count(b_ret), .halt_req(b_halt), .led(b_led));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TOUT
  int     m_st[2];
  longint m_cyc[2], m_ret[2], m_ft[2];
  int     m_ebrk[2] = '{0, 1};
  longint m_rmax[2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic model_zero(input int k);
    m_cyc[k] = 0; m_ret[k] = 0; m_ft[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit trig;
    if (rst || clear) begin
      m_st[k] = 0; model_zero(k);
    end else if (m_st[k] == 0) begin
      model_zero(k);
      if (run) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (!run) begin
        m_st[k] = 0; model_zero(k);
      end else begin
        trig = bus.inst_valid && (bus.inst == ECALL || (m_ebrk[k] != 0 && bus.inst == EBREAK));
        if (bus.inst_valid && m_ret[k] < m_rmax[k]) m_ret[k]++;
        if (trig) begin
          if (bus.gp_value == 32'd1) m_st[k] = 2;
          else begin m_st[k] = 3; m_ft[k] = longint'(bus.gp_value / 2); end
        end else if (m_cyc[k] == TOUT - 1) m_st[k] = 4;
        else m_cyc[k]++;
      end
    end
  endtask

  function automatic logic [7:0] model_led(input int k);
    case (m_st[k])
      2: return 8'h01;
      3: return 8'h80 | 8'(m_ft[k] % 128);
      4: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cmp_one(input int k, input logic [2:0] st, input logic dn, input logic ps,
                         input logic fl, input logic to, input logic hr, input logic [31:0] ft,
                         input logic [63:0] cc, input logic [63:0] rc, input logic [7:0] ld);
    string p;
    bit fin;
    p = (k == 0) ? "a" : "b";
    fin = (m_st[k] >= 2);
    chk({p, ".state"}, 64'(st), 64'(m_st[k]));
    chk({p, ".done"}, 64'(dn), 64'(fin));
    chk({p, ".halt_req"}, 64'(hr), 64'(fin));
    chk({p, ".pass"}, 64'(ps), 64'(m_st[k] == 2));
    chk({p, ".fail"}, 64'(fl), 64'(m_st[k] == 3));
    chk({p, ".timeout"}, 64'(to), 64'(m_st[k] == 4));
    chk({p, ".fail_test"}, 64'(ft), m_ft[k]);
    chk({p, ".cycle_count"}, cc, m_cyc[k]);
    chk({p, ".retired_count"}, rc, m_ret[k]);
    chk({p, ".led"}, 64'(ld), 64'(model_led(k)));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp_one(0, a_state, a_done, a_pass, a_fail, a_tout, a_halt, a_ft, 64'(a_cyc), 64'(a_ret), a_led);
    cmp_one(1, b_state, b_done, b_pass, b_fail, b_tout, b_halt, b_ft, 64'(b_cyc), 64'(b_ret), b_led);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] gp);
    bus.inst_valid = v; bus.inst = i; bus.gp_value = gp;
  endtask

  // Clear back to IDLE and enter RUN with run=1; leaves the bench on the RUN entry cycle
  task automatic restart();
    drive(1'b0, NOP, 32'd0);
    clear = 1'b1; run = 1'b1; tick();
    clear = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clear = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; model_zero(k); end

    tick(); tick();
    chk("reset.state", 64'(a_state), 64'd0);
    chk("reset.led", 64'(a_led), 64'h00);

    // Pass: 10 NOPs then ECALL with gp=1
    rst = 1'b0; run = 1'b1; tick();
    chk("t1.entry_cycle", 64'(a_cyc), 64'd0);
    for (int i = 0; i < 10; i++) begin drive(1'b1, NOP, 32'd0); tick(); end
    drive(1'b1, ECALL, 32'd1); tick();
    chk("t1.state", 64'(a_state), 64'd2);
    chk("t1.pass", 64'(a_pass), 64'd1);
    chk("t1.halt_req", 64'(a_halt), 64'd1);
    chk("t1.led", 64'(a_led), 64'h01);
    chk("t1.retired", 64'(a_ret), 64'd11);
    chk("t1.cycles", 64'(a_cyc), 64'd10);
    for (int i = 0; i < 20; i++) begin drive(1'(i), (i % 3 == 0) ? ECALL : NOP, $urandom); tick(); end
    chk("t1.sticky_state", 64'(a_state), 64'd2);
    chk("t1.sticky_cycles", 64'(a_cyc), 64'd10);

    // Fail with two gp values, clear in FAIL in between
    restart();
    drive(1'b1, ECALL, 32'd7); tick();
    chk("t2.state", 64'(a_state), 64'd3);
    chk("t2.fail_test", 64'(a_ft), 64'd3);
    chk("t2.led", 64'(a_led), 64'h83);
    drive(1'b0, NOP, 32'd0); clear = 1'b1; run = 1'b0; tick();
    clear = 1'b0;
    chk("t5.clear_fail_state", 64'(a_state), 64'd0);
    chk("t5.clear_fail_ft", 64'(a_ft), 64'd0);
    chk("t5.clear_fail_led", 64'(a_led), 64'h00);
    run = 1'b1; tick();
    drive(1'b1, ECALL, 32'h1F5); tick();
    chk("t2.fail_test2", 64'(a_ft), 64'hFA);
    chk("t2.led2", 64'(a_led), 64'hFA);

    // Timeout exactly TOUT cycles after RUN entry
    restart();
    for (int i = 0; i < TOUT - 1; i++) tick();
    chk("t3.still_run", 64'(a_state), 64'd1);
    tick();
    chk("t3.state", 64'(a_state), 64'd4);
    chk("t3.cycles", 64'(a_cyc), 64'd99);
    chk("t3.led", 64'(a_led), 64'hFF);
    chk("t3.timeout", 64'(a_tout), 64'd1);

    // Trigger on the timeout cycle wins
    restart();
    for (int i = 0; i < TOUT - 1; i++) tick();
    chk("t3.cyc99", 64'(a_cyc), 64'd99);
    drive(1'b1, ECALL, 32'd1); tick();
    chk("t3.trig_wins", 64'(a_state), 64'd2);

    // Trigger mode: EBREAK only ends the EBREAK-enabled instance; invalid ECALL ignored
    restart();
    drive(1'b1, EBREAK, 32'd1); tick();
    chk("t4.ebreak_off", 64'(a_state), 64'd1);
    chk("t4.ebreak_on", 64'(b_state), 64'd2);
    restart();
    drive(1'b0, ECALL, 32'd1); tick();
    chk("t4.invalid_a", 64'(a_state), 64'd1);
    chk("t4.invalid_b", 64'(b_state), 64'd1);

    // run dropped mid-test, then re-raised
    restart();
    drive(1'b0, NOP, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("t5.cyc40", 64'(a_cyc), 64'd40);
    run = 1'b0; tick();
    chk("t5.drop_state", 64'(a_state), 64'd0);
    chk("t5.drop_cyc", 64'(a_cyc), 64'd0);
    run = 1'b1; tick();
    chk("t5.restart_cyc", 64'(a_cyc), 64'd0);
    tick();
    chk("t5.restart_cyc1", 64'(a_cyc), 64'd1);
    drive(1'b1, ECALL, 32'd1); clear = 1'b1; tick();
    clear = 1'b0;
    chk("t5.clear_vs_trig", 64'(a_state), 64'd0);

    // Reset in PASS and in RUN
    tick();
    drive(1'b1, ECALL, 32'd1); tick();
    chk("t6.in_pass", 64'(a_state), 64'd2);
    drive(1'b0, NOP, 32'd0); rst = 1'b1; tick();
    rst = 1'b0;
    chk("t6.rst_pass_state", 64'(a_state), 64'd0);
    chk("t6.rst_pass_halt", 64'(a_halt), 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin drive(1'b1, NOP, 32'd0); tick(); end
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t6.rst_run_ret", 64'(a_ret), 64'd0);
    chk("t6.rst_run_cyc", 64'(a_cyc), 64'd0);

    // Retired-count saturation on the 4-bit instance
    restart();
    for (int i = 0; i < 20; i++) begin drive(1'b1, NOP, 32'd0); tick(); end
    chk("t6.sat_b", 64'(b_ret), 64'hF);
    chk("t6.nosat_a", 64'(a_ret), 64'd20);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst   = ($urandom_range(0, 499) == 0);
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) run = ~run;
      r = $urandom_range(0, 99);
      drive(1'($urandom_range(0, 1)),
            (r < 2) ? ECALL : (r < 4) ? EBREAK : (r < 50) ? NOP : 32'($urandom),
            ($urandom_range(0, 1) == 1) ? 32'd1 : 32'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
